// File: rtl/rob_gen.sv
// ---------------------------------------------------------------------------
// rob_gen : parametrised reorder buffer for the Tomasulo out-of-order core.
//
// One in-order dispatch per cycle, completion from CDB broadcasts, at most
// one in-order retirement per cycle to the FRL/CFC/retirement RAT and the
// store buffer. Branch mispredicts trim the ROB back to (and including) the
// branch entry.
//
// Optional build macro: ROB_EXC_EN
//   Adds cdb_exc / rob_exception and a per-entry exception bit. An excepting
//   entry reaching the head discards the whole ROB instead of retiring.
//
// Ports
//   clk, rst_b            clock, asynchronous active-low reset
//   dis_*                 dispatch request/payload; dis_ready / dis_tag back
//   cdb_*                 completion broadcast (tag, store address)
//   sb_full               store buffer back-pressure on store retirement
//   flush, flush_tag      branch mispredict, tag of the branch (kept)
//   rob_full/empty/count  occupancy; rob_two_or_more_vacant for dispatch
//   rob_rdptr/wrptr       pointers including wrap-phase MSB
//   rob_commit*           head retirement strobe and head payload
// ---------------------------------------------------------------------------
module rob_gen #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  parameter int ADDR_W = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  // dispatch
  input  logic              dis_valid,
  output logic              dis_ready,
  output logic [TAG_W-1:0]  dis_tag,
  input  logic              dis_sw,
  input  logic              dis_reg_write,
  input  logic [AREG_W-1:0] dis_rdaddr,
  input  logic [PREG_W-1:0] dis_new_phy,
  input  logic [PREG_W-1:0] dis_prev_phy,
  input  logic [PREG_W-1:0] dis_sw_rt_phy,
  // completion
  input  logic              cdb_val,
  input  logic [TAG_W-1:0]  cdb_robtag,
  input  logic [ADDR_W-1:0] cdb_swaddr,
`ifdef ROB_EXC_EN
  input  logic              cdb_exc,
  output logic              rob_exception,
`endif
  // control
  input  logic              sb_full,
  input  logic              flush,
  input  logic [TAG_W-1:0]  flush_tag,
  // status
  output logic              rob_full,
  output logic              rob_empty,
  output logic [TAG_W:0]    rob_count,
  output logic              rob_two_or_more_vacant,
  output logic [TAG_W:0]    rob_rdptr,
  output logic [TAG_W:0]    rob_wrptr,
  // retirement
  output logic              rob_commit,
  output logic              rob_commit_regwrite,
  output logic [AREG_W-1:0] rob_commit_rdaddr,
  output logic [PREG_W-1:0] rob_commit_prephy,
  output logic [PREG_W-1:0] rob_commit_currphy,
  output logic              rob_commit_memwrite,
  output logic [ADDR_W-1:0] rob_commit_swaddr,
  output logic [PREG_W-1:0] rob_commit_swphy
);

  localparam int PTR_W = TAG_W + 1;

  // pointers and per-entry control bits (reset)
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] cmpl_q, cmpl_d;
  logic [DEPTH-1:0] memwr_q, memwr_d;
  logic [DEPTH-1:0] regwr_q, regwr_d;

  // per-entry payload (no reset needed: only read behind control bits)
  logic [AREG_W-1:0] rdaddr_q  [DEPTH];
  logic [PREG_W-1:0] prephy_q  [DEPTH];
  // For stores this field holds the store data register instead of the
  // new destination, since stores have no destination mapping.
  logic [PREG_W-1:0] currphy_q [DEPTH];
  logic [ADDR_W-1:0] swaddr_q  [DEPTH];

  logic [TAG_W-1:0] head, wr_idx;
  logic [TAG_W-1:0] cdb_off, flush_off;
  logic [PTR_W-1:0] count;
  logic             cdb_live, flush_live;
  logic             dis_fire, cdb_fire, exc_fire;

  assign head   = rd_ptr_q[TAG_W-1:0];
  assign wr_idx = wr_ptr_q[TAG_W-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;

  // distance of a tag from the head; a tag is live when it lies inside
  // the occupied window
  assign cdb_off    = cdb_robtag - head;
  assign flush_off  = flush_tag - head;
  assign cdb_live   = {1'b0, cdb_off} < count;
  assign flush_live = {1'b0, flush_off} < count;

`ifdef ROB_EXC_EN
  logic [DEPTH-1:0] exc_q, exc_d;
  assign exc_fire      = ~rob_empty & cmpl_q[head] & exc_q[head];
  assign rob_exception = exc_fire;
`else
  assign exc_fire = 1'b0;
`endif

  // ---- status ----
  assign rob_count              = count;
  assign rob_empty              = (wr_ptr_q == rd_ptr_q);
  assign rob_full               = (wr_ptr_q[TAG_W-1:0] == rd_ptr_q[TAG_W-1:0]) &
                                  (wr_ptr_q[TAG_W] != rd_ptr_q[TAG_W]);
  assign rob_two_or_more_vacant = (count <= PTR_W'(DEPTH - 2));
  assign rob_rdptr              = rd_ptr_q;
  assign rob_wrptr              = wr_ptr_q;

  // ---- retirement ----
  assign rob_commit = ~rob_empty & cmpl_q[head] & (~memwr_q[head] | ~sb_full) & ~exc_fire;
  assign rob_commit_memwrite = rob_commit & memwr_q[head];
  assign rob_commit_regwrite = regwr_q[head];
  assign rob_commit_rdaddr   = rdaddr_q[head];
  assign rob_commit_prephy   = prephy_q[head];
  assign rob_commit_currphy  = currphy_q[head];
  assign rob_commit_swaddr   = swaddr_q[head];
  assign rob_commit_swphy    = currphy_q[head];

  // ---- dispatch ----
  // A full ROB can still accept when the head retires in the same cycle.
  assign dis_ready = ~flush & ~exc_fire & (~rob_full | rob_commit);
  assign dis_tag   = wr_idx;
  assign dis_fire  = dis_valid & dis_ready;

  // ---- completion ----
  // During a flush only entries up to and including the branch survive, so
  // a broadcast to a trimmed entry is dropped.
  assign cdb_fire = cdb_val & cdb_live & ~exc_fire &
                    (~flush | (cdb_off <= flush_off));

  // ---- next state ----
  always_comb begin
    rd_ptr_d = rd_ptr_q + {{TAG_W{1'b0}}, rob_commit};
    wr_ptr_d = wr_ptr_q;
    cmpl_d   = cmpl_q;
    memwr_d  = memwr_q;
    regwr_d  = regwr_q;
`ifdef ROB_EXC_EN
    exc_d    = exc_q;
`endif

    if (exc_fire)
      wr_ptr_d = rd_ptr_q;
    else if (flush)
      // keep the branch: head + distance + 1, carried in full pointer width
      // so the phase bit follows a wrap
      wr_ptr_d = rd_ptr_q + {1'b0, flush_off} + PTR_W'(1);
    else if (dis_fire)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (cdb_fire) begin
      cmpl_d[cdb_robtag] = 1'b1;
`ifdef ROB_EXC_EN
      exc_d[cdb_robtag]  = cdb_exc;
`endif
    end

    if (rob_commit)
      cmpl_d[head] = 1'b0;

    if (dis_fire) begin
      cmpl_d[wr_idx]  = 1'b0;
      memwr_d[wr_idx] = dis_sw;
      regwr_d[wr_idx] = dis_reg_write;
`ifdef ROB_EXC_EN
      exc_d[wr_idx]   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cmpl_q   <= '0;
      memwr_q  <= '0;
      regwr_q  <= '0;
`ifdef ROB_EXC_EN
      exc_q    <= '0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cmpl_q   <= cmpl_d;
      memwr_q  <= memwr_d;
      regwr_q  <= regwr_d;
`ifdef ROB_EXC_EN
      exc_q    <= exc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (dis_fire) begin
      rdaddr_q[wr_idx]  <= dis_rdaddr;
      prephy_q[wr_idx]  <= dis_prev_phy;
      currphy_q[wr_idx] <= dis_sw ? dis_sw_rt_phy : dis_new_phy;
    end
    if (cdb_fire && memwr_q[cdb_robtag])
      swaddr_q[cdb_robtag] <= cdb_swaddr;
  end

  // a mispredicted branch must still be in flight
  a_flush_live: assert property (@(posedge clk) disable iff (!rst_b) flush |-> flush_live)
    else $error("flush_tag not live");

endmodule

// File: tb/tb_rob_gen.sv
module tb_rob_gen;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        dis_valid = 0, dis_sw = 0, dis_reg_write = 0;
  logic        dis_ready;
  logic [4:0]  dis_tag;
  logic [4:0]  dis_rdaddr = '0;
  logic [5:0]  dis_new_phy = '0, dis_prev_phy = '0, dis_sw_rt_phy = '0;
  logic        cdb_val = 0;
  logic [4:0]  cdb_robtag = '0;
  logic [31:0] cdb_swaddr = '0;
  logic        sb_full = 0, flush = 0;
  logic [4:0]  flush_tag = '0;
  logic        rob_full, rob_empty, rob_two_or_more_vacant;
  logic [5:0]  rob_count, rob_rdptr, rob_wrptr;
  logic        rob_commit, rob_commit_regwrite, rob_commit_memwrite;
  logic [4:0]  rob_commit_rdaddr;
  logic [5:0]  rob_commit_prephy, rob_commit_currphy, rob_commit_swphy;
  logic [31:0] rob_commit_swaddr;
`ifdef ROB_EXC_EN
  logic        cdb_exc = 0;
  logic        rob_exception;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_gen dut (
    .clk(clk), .rst_b(rst_b),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_tag(dis_tag),
    .dis_sw(dis_sw), .dis_reg_write(dis_reg_write), .dis_rdaddr(dis_rdaddr),
    .dis_new_phy(dis_new_phy), .dis_prev_phy(dis_prev_phy), .dis_sw_rt_phy(dis_sw_rt_phy),
    .cdb_val(cdb_val), .cdb_robtag(cdb_robtag), .cdb_swaddr(cdb_swaddr),
`ifdef ROB_EXC_EN
    .cdb_exc(cdb_exc), .rob_exception(rob_exception),
`endif
    .sb_full(sb_full), .flush(flush), .flush_tag(flush_tag),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
    .rob_two_or_more_vacant(rob_two_or_more_vacant),
    .rob_rdptr(rob_rdptr), .rob_wrptr(rob_wrptr),
    .rob_commit(rob_commit), .rob_commit_regwrite(rob_commit_regwrite),
    .rob_commit_rdaddr(rob_commit_rdaddr), .rob_commit_prephy(rob_commit_prephy),
    .rob_commit_currphy(rob_commit_currphy), .rob_commit_memwrite(rob_commit_memwrite),
    .rob_commit_swaddr(rob_commit_swaddr), .rob_commit_swphy(rob_commit_swphy)
  );

  typedef struct {
    logic       dv;
    logic [4:0] ra;    // dispatched rdaddr
    logic       cv;
    logic [4:0] ctag;
    logic [5:0] cnt;   // expected count before the edge
    logic       cmt;   // expected rob_commit
    logic [4:0] dtag;  // expected dis_tag
    logic [4:0] crd;   // expected head rdaddr when committing
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dis_valid = 0; dis_sw = 0; dis_reg_write = 0;
    cdb_val = 0; sb_full = 0; flush = 0;
`ifdef ROB_EXC_EN
    cdb_exc = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst_b = 0;
    tick();
    rst_b = 1;
  endtask

  function automatic vec_t mk(logic dv, logic [4:0] ra, logic cv, logic [4:0] ctag,
                              logic [5:0] cnt, logic cmt, logic [4:0] dtag, logic [4:0] crd);
    vec_t v;
    v.dv = dv; v.ra = ra; v.cv = cv; v.ctag = ctag;
    v.cnt = cnt; v.cmt = cmt; v.dtag = dtag; v.crd = crd;
    return v;
  endfunction

  initial begin
    //          dv ra  cv ctag cnt cmt dtag crd
    tbl[0] = mk(1, 1,  0, 0,   0,  0,  0,   0);
    tbl[1] = mk(1, 2,  0, 0,   1,  0,  1,   0);
    tbl[2] = mk(1, 3,  0, 0,   2,  0,  2,   0);
    tbl[3] = mk(0, 0,  1, 1,   3,  0,  3,   0);
    tbl[4] = mk(0, 0,  1, 0,   3,  0,  3,   0);
    tbl[5] = mk(0, 0,  0, 0,   3,  1,  3,   1);
    tbl[6] = mk(0, 0,  0, 0,   2,  1,  3,   2);
    tbl[7] = mk(0, 0,  0, 0,   1,  0,  3,   0);

    // ---- reset state ----
    tick();
    @(negedge clk);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_count", rob_count, 0);
    chk("rst_vacant", rob_two_or_more_vacant, 1);
    chk("rst_commit", rob_commit, 0);
    chk("rst_memwrite", rob_commit_memwrite, 0);
    chk("rst_ready", dis_ready, 1);
    rst_b = 1;
    tick();

    // ---- basic dispatch / out-of-order completion / in-order commit ----
    for (int i = 0; i < 8; i++) begin
      dis_valid = tbl[i].dv; dis_reg_write = tbl[i].dv;
      dis_rdaddr = tbl[i].ra;
      dis_new_phy = {1'b0, tbl[i].ra} + 6'd8;
      dis_prev_phy = {1'b0, tbl[i].ra} + 6'd16;
      cdb_val = tbl[i].cv; cdb_robtag = tbl[i].ctag;
      @(negedge clk);
      chk($sformatf("t%0d_count", i), rob_count, tbl[i].cnt);
      chk($sformatf("t%0d_commit", i), rob_commit, tbl[i].cmt);
      chk($sformatf("t%0d_ready", i), dis_ready, 1);
      chk($sformatf("t%0d_distag", i), dis_tag, tbl[i].dtag);
      if (tbl[i].cmt) begin
        chk($sformatf("t%0d_rdaddr", i), rob_commit_rdaddr, tbl[i].crd);
        chk($sformatf("t%0d_currphy", i), rob_commit_currphy, {1'b0, tbl[i].crd} + 6'd8);
        chk($sformatf("t%0d_prephy", i), rob_commit_prephy, {1'b0, tbl[i].crd} + 6'd16);
        chk($sformatf("t%0d_regwrite", i), rob_commit_regwrite, 1);
      end
      tick();
    end
    idle();

    // ---- asynchronous reset with one entry still live ----
    #2;
    rst_b = 0;
    #1;
    chk("async_rst_empty", rob_empty, 1);
    chk("async_rst_count", rob_count, 0);
    tick();
    rst_b = 1;

    // ---- fill, then commit+dispatch while full ----
    for (int i = 0; i < 32; i++) begin
      dis_valid = 1; dis_reg_write = 1; dis_rdaddr = 5'(i);
      @(negedge clk);
      if (i == 30) chk("fill_vacant30", rob_two_or_more_vacant, 1);
      if (i == 31) begin
        chk("fill_vacant31", rob_two_or_more_vacant, 0);
        chk("fill_tag31", dis_tag, 31);
      end
      tick();
    end
    @(negedge clk);
    chk("full_flag", rob_full, 1);
    chk("full_ready", dis_ready, 0);
    chk("full_count", rob_count, 32);
    chk("full_wrptr", rob_wrptr, 6'd32);
    tick();
    cdb_val = 1; cdb_robtag = 0;
    @(negedge clk);
    chk("full_cdb_commit", rob_commit, 0);
    tick();
    cdb_val = 0;
    @(negedge clk);
    chk("full_cd_commit", rob_commit, 1);
    chk("full_cd_ready", dis_ready, 1);
    chk("full_cd_tag", dis_tag, 0);
    tick();
    dis_valid = 0;
    @(negedge clk);
    chk("full_cd_count", rob_count, 32);
    chk("full_cd_wrptr", rob_wrptr, 6'd33);
    chk("full_cd_rdptr", rob_rdptr, 6'd1);

    // ---- store held by store buffer back-pressure ----
    do_reset();
    dis_valid = 1; dis_sw = 1; dis_sw_rt_phy = 6'd7;
    tick();
    idle();
    cdb_val = 1; cdb_robtag = 0; cdb_swaddr = 32'hDEAD_BEEF; sb_full = 1;
    tick();
    cdb_val = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("sb_hold%0d_commit", i), rob_commit, 0);
      chk($sformatf("sb_hold%0d_memwrite", i), rob_commit_memwrite, 0);
      tick();
    end
    sb_full = 0;
    @(negedge clk);
    chk("sb_commit", rob_commit, 1);
    chk("sb_memwrite", rob_commit_memwrite, 1);
    chk("sb_swaddr", rob_commit_swaddr, 32'hDEAD_BEEF);
    chk("sb_swphy", rob_commit_swphy, 7);
    chk("sb_regwrite", rob_commit_regwrite, 0);
    tick();
    @(negedge clk);
    chk("sb_empty_after", rob_empty, 1);

    // ---- flush across the wrap point ----
    do_reset();
    for (int i = 0; i < 30; i++) begin
      dis_valid = 1; tick();
    end
    dis_valid = 0;
    for (int i = 0; i < 30; i++) begin
      cdb_val = 1; cdb_robtag = 5'(i); tick();
    end
    cdb_val = 0;
    tick(); tick();
    @(negedge clk);
    chk("wrap_drain_empty", rob_empty, 1);
    chk("wrap_drain_rdptr", rob_rdptr, 6'd30);
    tick();
    for (int i = 0; i < 6; i++) begin
      dis_valid = 1; tick();
    end
    dis_valid = 0;
    @(negedge clk);
    chk("wrap_count6", rob_count, 6);
    chk("wrap_wrptr36", rob_wrptr, 6'd36);
    tick();
    flush = 1; flush_tag = 0; cdb_val = 1; cdb_robtag = 31; dis_valid = 1;
    @(negedge clk);
    chk("flush_ready", dis_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("flush_wrptr", rob_wrptr, 6'd33);
    chk("flush_count", rob_count, 3);
    tick();
    cdb_val = 1; cdb_robtag = 2;               // trimmed tag, ignored
    @(negedge clk);
    chk("stale_commit", rob_commit, 0);
    tick();
    cdb_robtag = 30;
    @(negedge clk);
    chk("stale_count", rob_count, 3);
    tick();
    cdb_val = 0;
    @(negedge clk);
    chk("post_flush_c30", rob_commit, 1);
    chk("post_flush_cnt3", rob_count, 3);
    tick();
    @(negedge clk);
    chk("flush_cycle_cdb31", rob_commit, 1);
    chk("post_flush_cnt2", rob_count, 2);
    tick();
    @(negedge clk);
    chk("head0_not_done", rob_commit, 0);
    chk("post_flush_cnt1", rob_count, 1);
    tick();
    cdb_val = 1; cdb_robtag = 0;
    tick();
    idle();

    // ---- flush to the head in the cycle it commits ----
    flush = 1; flush_tag = 0; dis_valid = 1;
    @(negedge clk);
    chk("fhead_commit", rob_commit, 1);
    chk("fhead_ready", dis_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("fhead_empty", rob_empty, 1);
    chk("fhead_count", rob_count, 0);
    chk("fhead_wrptr", rob_wrptr, 6'd33);
    chk("fhead_rdptr", rob_rdptr, 6'd33);

`ifdef ROB_EXC_EN
    // ---- excepting head discards the ROB ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dis_valid = 1; tick();
    end
    idle();
    cdb_val = 1; cdb_robtag = 0; cdb_exc = 1;
    tick();
    idle();
    dis_valid = 1;
    @(negedge clk);
    chk("exc_pulse", rob_exception, 1);
    chk("exc_commit", rob_commit, 0);
    chk("exc_ready", dis_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("exc_count", rob_count, 0);
    chk("exc_pulse_end", rob_exception, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
